// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// UART receive sequencer. It watches an oversampled serial line and drives
// the strobes of an external 10-bit receive shift register. It finds the
// start bit, samples each data bit and the stop bit at mid-bit, and flags
// framing errors.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// between data bit 7 and the stop bit. When it is undefined, framing is 8N1
// and parity_err is tied to 0.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   rx           raw serial line, idle high
//   baud_tick    one-clk enable at OVERSAMPLE x baud rate
//   rx_bit       synchronised line value (shift register data_in)
//   ld_sr        load rx_bit into shift register bit 9
//   shift_right  shift the shift register right by one
//   ld_rx        copy shift register [7:0] to its data_out
//   rx_valid     one-cycle pulse: byte stable on data_out
//   frame_err    one-cycle pulse: stop bit sampled as 0
//   parity_err   one-cycle pulse with rx_valid on parity mismatch
//   busy         high in every state except IDLE
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic baud_tick,
  output logic rx_bit,
  output logic ld_sr,
  output logic shift_right,
  output logic ld_rx,
  output logic rx_valid,
  output logic frame_err,
  output logic parity_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

  // LOAD waits out the stop-bit shift_right before issuing ld_rx.
  // DONE keeps busy high during the rx_valid pulse.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_LOAD,
    S_DONE,
    S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      bit_q, bit_d;
  logic            shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic            par_acc_q, par_acc_d;
  logic            par_fail_q, par_fail_d;
`endif

  // Two-flop synchroniser. It resets to the idle line level, so reset
  // cannot look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and counter registers. shift_q is the pending shift_right that
  // follows every ld_sr by exactly one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= 1'b0;
      par_fail_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= par_acc_d;
      par_fail_q <= par_fail_d;
`endif
    end
  end

  // Next-state and strobe logic. ld_sr is combinational so that it is
  // coincident with the qualifying baud_tick.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = 1'b0;
    ld_sr      = 1'b0;
    ld_rx      = 1'b0;
    rx_valid   = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d  = par_acc_q;
    par_fail_d = par_fail_q;
    parity_err = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      // Re-check the line half a bit later. A high line here is a glitch.
      S_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            bit_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_acc_d  = 1'b0;
            par_fail_d = 1'b0;
`endif
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            ld_sr   = 1'b1;
            shift_d = 1'b1;
            bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            par_acc_d = par_acc_q ^ rx_s_q;
`endif
            if (bit_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // The parity bit is checked but never enters the shift register.
      S_PARITY: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            par_fail_d = par_acc_q ^ rx_s_q;
            state_d    = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif

      // The stop bit is shifted in like a data bit. This leaves data bit 0
      // at shift register [0].
      S_STOP: begin
        if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            ld_sr   = 1'b1;
            shift_d = 1'b1;
            if (rx_s_q) begin
              state_d = S_LOAD;
            end else begin
              frame_err = 1'b1;
              state_d   = S_WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (!shift_q) begin
          ld_rx   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rx_valid = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err = par_fail_q;
`endif
        state_d = S_IDLE;
      end

      // A break or a stuck-low line must return high before a new frame.
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign rx_bit      = rx_s_q;
  assign shift_right = shift_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. It models the external 10-bit
// receive shift register and drives it from the DUT strobes. Each frame sent
// pushes its expected outcome onto a scoreboard queue. A negedge monitor pops
// that outcome when rx_valid or frame_err fires, and it also checks the
// relative timing of the strobes.
module tb_uart_rx_ctrl;

  localparam int OS      = 16;
  localparam int TICKDIV = 4;
  localparam int BITCLK  = OS * TICKDIV;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic baud_tick;
  logic rx_bit, ld_sr, shift_right, ld_rx, rx_valid, frame_err, parity_err, busy;

  typedef struct {
    bit         isFrameErr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t expQ[$];

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [9:0] srModel;
  logic [7:0] dataOut;

  int ldSrCnt = 0, shiftCnt = 0, ldRxCnt = 0, busyRun = 0;

  uart_rx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .baud_tick   (baud_tick),
    .rx_bit      (rx_bit),
    .ld_sr       (ld_sr),
    .shift_right (shift_right),
    .ld_rx       (ld_rx),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // baud_tick is high for one clk out of every TICKDIV.
  initial begin
    int phase;
    phase     = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (phase == TICKDIV - 1);
      phase     = (phase + 1) % TICKDIV;
    end
  end

  // Model of the external receive shift register.
  always @(posedge clk) begin
    if (ld_sr)            srModel[9] <= rx_bit;
    else if (shift_right) srModel    <= {1'b0, srModel[9:1]};
    if (ld_rx)            dataOut    <= srModel[7:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    #1 rx = b;
    repeat (BITCLK) @(posedge clk);
  endtask

  task automatic idle(input int n);
    #1 rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Sends one frame and records its expected outcome. parFlip inverts the
  // parity bit (this only has an effect in the parity build).
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parFlip);
    exp_t e;
    e.isFrameErr = !stopBit;
    e.data       = data;
`ifdef UART_RX_PARITY_EN
    e.perr = parFlip;
`else
    e.perr = 1'b0;
`endif
    expQ.push_back(e);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit((^data) ^ parFlip);
`endif
    driveBit(stopBit);
  endtask

  // Monitor: strobe timing rules, per-frame strobe counts and the scoreboard.
  initial begin
    logic prevLdSr, prevShift, prevLdRx, prevValid, prevBusy, prevRst;
    exp_t e;
    prevLdSr = 0; prevShift = 0; prevLdRx = 0; prevValid = 0; prevBusy = 0; prevRst = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevLdSr = 0; prevShift = 0; prevLdRx = 0; prevValid = 0; prevBusy = 0;
        prevRst  = 1;
      end else begin
        if (busy && !prevBusy) begin
          ldSrCnt = 0; shiftCnt = 0; ldRxCnt = 0; busyRun = 0;
        end
        if (busy) busyRun++;
        ldSrCnt  += int'(ld_sr);
        shiftCnt += int'(shift_right);
        ldRxCnt  += int'(ld_rx);

        checkOutput("strobeExclusive",
                    32'((int'(ld_sr) + int'(shift_right) + int'(ld_rx)) <= 1), 32'd1);
        if (!prevRst) checkOutput("shiftFollowsLdSr", 32'(shift_right), 32'(prevLdSr));
        if (ld_rx)    checkOutput("ldRxAfterShift", 32'(prevShift), 32'd1);
        if (prevValid) checkOutput("busyFallAfterValid", 32'(busy), 32'd0);

        if (rx_valid) begin
          checkOutput("validAfterLdRx", 32'(prevLdRx), 32'd1);
          checkOutput("busyDuringValid", 32'(busy), 32'd1);
          if (expQ.size() == 0) begin
            checkOutput("unexpectedValid", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("kindValid", 32'(e.isFrameErr), 32'd0);
            checkOutput("dataOut", 32'(dataOut), 32'(e.data));
            checkOutput("parityErr", 32'(parity_err), 32'(e.perr));
            checkOutput("ldSrCount", 32'(ldSrCnt), 32'd9);
            checkOutput("shiftCount", 32'(shiftCnt), 32'd9);
            checkOutput("ldRxCount", 32'(ldRxCnt), 32'd1);
          end
        end
        if (frame_err) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedFrameErr", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("kindFrameErr", 32'(e.isFrameErr), 32'd1);
            checkOutput("ldSrCountFerr", 32'(ldSrCnt), 32'd9);
          end
        end
        prevLdSr  = ld_sr;
        prevShift = shift_right;
        prevLdRx  = ld_rx;
        prevValid = rx_valid;
        prevBusy  = busy;
        prevRst   = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstLdSr", 32'(ld_sr), 32'd0);
    checkOutput("rstShift", 32'(shift_right), 32'd0);
    checkOutput("rstLdRx", 32'(ld_rx), 32'd0);
    checkOutput("rstValid", 32'(rx_valid), 32'd0);
    checkOutput("rstFrameErr", 32'(frame_err), 32'd0);
    checkOutput("rstParityErr", 32'(parity_err), 32'd0);
    checkOutput("rstRxBit", 32'(rx_bit), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    $display("[TB] byte 0xA5");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    idle(40);

    $display("[TB] start-bit glitch");
    #1 rx = 1'b0;
    repeat (3 * TICKDIV) @(posedge clk);
    idle(80);
    @(negedge clk);
    checkOutput("glitchBusy", 32'(busy), 32'd0);
    checkOutput("glitchLdSr", 32'(ldSrCnt), 32'd0);
    checkOutput("glitchShift", 32'(shiftCnt), 32'd0);
    checkOutput("glitchLdRx", 32'(ldRxCnt), 32'd0);
    checkOutput("glitchBusyLen", 32'(busyRun > 0 && busyRun <= (OS / 2) * TICKDIV), 32'd1);

    $display("[TB] framing error then line held low");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (40 * TICKDIV) @(posedge clk);
    @(negedge clk);
    checkOutput("waitIdleBusy", 32'(busy), 32'd1);
    checkOutput("ferrNoLdRx", 32'(ldRxCnt), 32'd0);
    idle(10);
    @(negedge clk);
    checkOutput("waitIdleExit", 32'(busy), 32'd0);
    idle(20);
    applyStimulus(8'h81, 1'b1, 1'b0);
    idle(40);

    $display("[TB] reset during data bit 4 of 0xFF");
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    repeat (BITCLK / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstShift", 32'(shift_right), 32'd0);
    checkOutput("midRstLdSr", 32'(ld_sr), 32'd0);
    checkOutput("midRstLdRx", 32'(ld_rx), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(BITCLK * 6);
    @(negedge clk);
    checkOutput("postRstIdle", 32'(busy), 32'd0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    idle(40);

    $display("[TB] back-to-back 0x55 0xAA");
    applyStimulus(8'h55, 1'b1, 1'b0);
    applyStimulus(8'hAA, 1'b1, 1'b0);
    idle(40);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity good and bad on 0x07");
    applyStimulus(8'h07, 1'b1, 1'b0);
    idle(40);
    applyStimulus(8'h07, 1'b1, 1'b1);
    idle(40);
`endif

    idle(100);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer that drives the 10-bit receive shift register's `ld_sr`, `shift_right` and `ld_rx` strobes from an oversampled serial line. It detects the start bit, samples each data and stop bit at mid-bit, validates the stop bit and flags framing errors. It sits between the baud-rate generator and the receive shift register, and signals the RX FIFO write side when a byte is ready.

## Interface
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period. Must be even and at least 4.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: raw serial line, idle high. Synchronised internally.
- `baud_tick` input 1: one-`clk` enable pulse at OVERSAMPLE × baud rate.
- `rx_bit` output 1: synchronised line value. Wire to the shift register `data_in`.
- `ld_sr` output 1: load `rx_bit` into shift register bit 9.
- `shift_right` output 1: shift the shift register right by 1.
- `ld_rx` output 1: copy shift register [7:0] to its `data_out`.
- `rx_valid` output 1: one-cycle pulse; byte is stable on the shift register `data_out`.
- `frame_err` output 1: one-cycle pulse; stop bit sampled as 0.
- `parity_err` output 1: one-cycle pulse; parity mismatch. Constant 0 when parity is not compiled in.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. `rx_bit` = `rx_s`.
- Counters:
  - `tick_cnt` is $clog2(OVERSAMPLE) bits wide and counts `baud_tick` pulses only.
  - `bit_cnt` is 4 bits wide.
- **IDLE**
  - `tick_cnt` = 0.
  - `rx_s` == 0 → START.
- **START**
  - On the `baud_tick` where `tick_cnt` == OVERSAMPLE/2−1:
    - if `rx_s` == 0 → DATA, with `tick_cnt` = 0 and `bit_cnt` = 0;
    - else → IDLE (glitch rejected, no strobes).
- **DATA**
  - On the `baud_tick` where `tick_cnt` == OVERSAMPLE−1: assert `ld_sr` for that `clk`; `shift_right` follows in the next `clk`.
  - `bit_cnt` increments on each sample.
  - After the 8th sample:
    - → PARITY if parity is compiled in;
    - else → STOP.
- **PARITY** (only when parity is compiled in)
  - Sample at `tick_cnt` == OVERSAMPLE−1.
  - No `ld_sr` and no `shift_right`.
  - Store the even-parity check result, then → STOP.
- **STOP**
  - Sample at `tick_cnt` == OVERSAMPLE−1 and issue `ld_sr` then `shift_right` in the same way as a data bit.
  - The 9th shift places data bit 0 at shift register [0]. Data is LSB first.
  - If the stop bit == 1 → LOAD.
  - If the stop bit == 0 → pulse `frame_err` and go to WAIT_IDLE. No `ld_rx`.
- **LOAD**
  - Assert `ld_rx` for one `clk`.
  - Next `clk`: pulse `rx_valid`, pulse `parity_err` if the stored check failed, and → IDLE.
- **WAIT_IDLE**
  - Stay until `rx_s` == 1, then → IDLE (break and line-low recovery).
- Strobe rules:
  - `ld_sr`, `shift_right` and `ld_rx` are mutually exclusive in every cycle.
  - Strobes are never asserted outside the sampling sequence.
- A parity error does not suppress `ld_rx`. The byte is delivered and flagged.

## Timing
- Reset values:
  - All strobes and error pulses: 0.
  - `busy` = 0; state = IDLE; counters = 0; synchroniser = 1.
- `rst` asserted mid-frame aborts immediately. No partial `ld_rx` is issued.
- Input latency: `rx` to `rx_s` is 2 `clk`.
- Strobe timing:
  - `ld_sr` is coincident with the qualifying `baud_tick` cycle.
  - `shift_right` comes exactly 1 `clk` later.
  - `ld_rx` comes 1 `clk` after the stop-bit `shift_right`.
  - `rx_valid` comes 1 `clk` after `ld_rx`.
- A `baud_tick` that lands in the `shift_right` cycle is still counted. Counting never stalls.
- `baud_tick` must be spaced at least 3 `clk` apart. Closer spacing is unsupported.
- `busy` rises 1 `clk` after `rx_s` falls in IDLE. It falls in the cycle after `rx_valid`, or when leaving WAIT_IDLE.
- The next start bit is accepted from the cycle after IDLE is re-entered.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists;
  - one even-parity bit is expected between data bit 7 and the stop bit;
  - `parity_err` is driven.
- Not defined:
  - 8N1 framing;
  - the PARITY state is absent;
  - `parity_err` is tied to 0.

## Test plan
- 8N1 byte 0xA5 at OVERSAMPLE=16 with `baud_tick` every 4 `clk` → 9 `ld_sr`/`shift_right` pairs, then 1 `ld_rx`, then `rx_valid`; shift register `data_out` = 0xA5; `frame_err` = 0.
- 3-tick low glitch on idle line → return to IDLE; no strobes; `busy` high for under OVERSAMPLE/2 ticks.
- 0x3C sent with stop bit 0 → `frame_err` pulse, no `ld_rx`; `rx` held low 40 ticks stays in WAIT_IDLE; a following 0x81 is received correctly.
- `rst` pulsed during data bit 4 of 0xFF → all outputs 0 and state IDLE; a following 0x12 yields `data_out` = 0x12.
- Back-to-back 0x55 then 0xAA with no idle gap → two `rx_valid` pulses with correct data each time.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `rx_valid` and `parity_err` = 0; parity bit 0 → `rx_valid` with `parity_err` = 1 and `data_out` = 0x07.
